// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: state encoding and
// field layout of the packed {last, src_id, data} FIFO word.
package fifo_arb_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_LOCK = 1'b1;

  typedef enum logic {
    StIdle = ST_IDLE,
    StLock = ST_LOCK
  } arb_state_e;

  // Bit position of the last flag in the FIFO word.
  function automatic int unsigned last_bit(int unsigned data_width, int unsigned id_width);
    return data_width + id_width;
  endfunction

  // LSB of the source-ID field in the FIFO word.
  function automatic int unsigned id_lsb(int unsigned data_width);
    return data_width;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin first-one finder: searches req_i starting at
// ptr_i and wrapping modulo NumReq.
module rr_pick #(
  parameter int unsigned NumReq  = 4,
  parameter int unsigned IdWidth = $clog2(NumReq)
) (
  input  logic [NumReq-1:0]  req_i,
  input  logic [IdWidth-1:0] ptr_i,
  output logic [IdWidth-1:0] grant_o,
  output logic               any_o
);

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    grant_o = '0;
    any_o   = 1'b0;
    for (int i = int'(NumReq) - 1; i >= 0; i--) begin
      automatic int unsigned idx = (32'(ptr_i) + 32'(i)) % NumReq;
      if (req_i[idx]) begin
        grant_o = IdWidth'(idx);
        any_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter sharing one sync_fifo write port among
// NumReq valid/ready producers. Beats go to the FIFO tagged {last, id, data}.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned DataWidth = 8,
  parameter int unsigned MaxBeats  = 16,
  localparam int unsigned IdWidth  = $clog2(NumReq)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumReq-1:0]              req_valid_i,
  input  logic [NumReq*DataWidth-1:0]    req_data_i,
  input  logic [NumReq-1:0]              req_last_i,
  output logic [NumReq-1:0]              req_ready_o,
  output logic                           fifo_wr_en_o,
  output logic [DataWidth+IdWidth:0]     fifo_wr_data_o,
  input  logic                           fifo_wr_full_i,
  output logic                           busy_o,
  output logic [IdWidth-1:0]             owner_o,
  output logic                           trunc_err_o
);

  localparam int unsigned CntW    = (MaxBeats > 1) ? $clog2(MaxBeats) : 1;
  localparam int unsigned LastBit = last_bit(DataWidth, IdWidth);
  localparam int unsigned IdLsb   = id_lsb(DataWidth);
  localparam logic [CntW-1:0]    CapCnt = CntW'(MaxBeats - 1);
  localparam logic [IdWidth-1:0] LastId = IdWidth'(NumReq - 1);

  arb_state_e          state_q;
  logic [IdWidth-1:0]  rr_ptr_q;
  logic [IdWidth-1:0]  owner_q;
  logic [CntW-1:0]     beat_cnt_q;
  logic                trunc_err_q;

  logic [IdWidth-1:0]   grant;
  logic                 any_req;
  logic                 owner_valid;
  logic                 owner_last;
  logic [DataWidth-1:0] owner_data;
  logic                 eff_last;
  logic                 accept;
  logic [IdWidth-1:0]   next_ptr;

  rr_pick #(
    .NumReq  (NumReq),
    .IdWidth (IdWidth)
  ) u_rr_pick (
    .req_i   (req_valid_i),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .any_o   (any_req)
  );

  assign owner_valid = req_valid_i[owner_q];
  assign owner_last  = req_last_i[owner_q];
  assign owner_data  = req_data_i[owner_q*DataWidth +: DataWidth];
  // The cap forces last on the MaxBeats-th beat even without producer last.
  assign eff_last    = owner_last | (beat_cnt_q == CapCnt);
  assign next_ptr    = (owner_q == LastId) ? '0 : owner_q + 1'b1;

  // Zero-latency beat path from the locked owner into the FIFO write port.
  always_comb begin
    req_ready_o    = '0;
    fifo_wr_en_o   = 1'b0;
    fifo_wr_data_o = '0;
    accept         = 1'b0;
    if (state_q == StLock) begin
      req_ready_o[owner_q]             = ~fifo_wr_full_i;
      accept                           = owner_valid & ~fifo_wr_full_i;
      fifo_wr_en_o                     = accept;
      fifo_wr_data_o[LastBit]          = eff_last;
      fifo_wr_data_o[IdLsb +: IdWidth] = owner_q;
      fifo_wr_data_o[0 +: DataWidth]   = owner_data;
    end
  end

  // Arbitration FSM: grant in IDLE, stream one packet in LOCK.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      beat_cnt_q  <= '0;
      trunc_err_q <= 1'b0;
    end else begin
      trunc_err_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (any_req) begin
            owner_q    <= grant;
            beat_cnt_q <= '0;
            state_q    <= StLock;
          end
        end
        StLock: begin
          if (accept) begin
            if (eff_last) begin
              state_q     <= StIdle;
              rr_ptr_q    <= next_ptr;
              beat_cnt_q  <= '0;
              // Only a cap-forced end is an error; a real last on the cap beat is not.
              trunc_err_q <= ~owner_last;
            end else begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o      = (state_q == StLock);
  assign owner_o     = owner_q;
  assign trunc_err_o = trunc_err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter (NumReq=4, DataWidth=8, MaxBeats=4).
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int IW = 2;
  localparam int WW = DW + IW + 1;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic            fifo_wr_en;
  logic [WW-1:0]   fifo_wr_data;
  logic            fifo_wr_full;
  logic            busy;
  logic [IW-1:0]   owner;
  logic            trunc_err;

  // Per-requester beat queues {last, data}, and the expected FIFO word stream.
  logic [8:0]    prod_q [NR][$];
  logic [WW-1:0] exp_q[$];
  int            wr_cyc[$];
  logic [NR-1:0] hold;
  logic [NR-1:0] acc;
  int cyc = 0;
  int wr_total = 0;
  int trunc_cnt = 0;
  int trunc_cyc = -1;
  int checks = 0;
  int errors = 0;

  fifo_wr_arbiter #(
    .NumReq    (NR),
    .DataWidth (DW),
    .MaxBeats  (MB)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_valid_i    (req_valid),
    .req_data_i     (req_data),
    .req_last_i     (req_last),
    .req_ready_o    (req_ready),
    .fifo_wr_en_o   (fifo_wr_en),
    .fifo_wr_data_o (fifo_wr_data),
    .fifo_wr_full_i (fifo_wr_full),
    .busy_o         (busy),
    .owner_o        (owner),
    .trunc_err_o    (trunc_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [WW-1:0] word(input logic l, input int id, input logic [7:0] d);
    return {l, 2'(id), d};
  endfunction

  function automatic int cyc_at(input int k);
    return (k < wr_cyc.size()) ? wr_cyc[k] : -1000;
  endfunction

  task automatic push_pkt(input int id, input logic [7:0] d, input logic l);
    prod_q[id].push_back({l, d});
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || prod_q[0].size() != 0 || prod_q[1].size() != 0 ||
            prod_q[2].size() != 0 || prod_q[3].size() != 0) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check_eq("drain", exp_q.size(), 0);
  endtask

  task automatic wait_writes(input int target, input int budget);
    int n = 0;
    while (wr_total < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check_eq("wait_wr", 32'(wr_total >= target), 1);
  endtask

  // Producer model: sample handshake at negedge, pop and re-present after posedge.
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      cyc++;
      #1;
      for (int i = 0; i < NR; i++) begin
        logic [8:0] head;
        if (acc[i] && prod_q[i].size() > 0) void'(prod_q[i].pop_front());
        head = (prod_q[i].size() > 0) ? prod_q[i][0] : 9'h0;
        req_valid[i]          = (prod_q[i].size() > 0) && !hold[i];
        req_last[i]           = head[8];
        req_data[i*DW +: DW]  = head[7:0];
      end
    end
  end

  // FIFO-side monitor: every accepted write is popped against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && fifo_wr_en) begin
      wr_total++;
      wr_cyc.push_back(cyc);
      if (exp_q.size() == 0) check_eq("sb_underflow", 32'(fifo_wr_data), 32'hdead);
      else check_eq("wr_word", 32'(fifo_wr_data), 32'(exp_q.pop_front()));
    end
    if (trunc_err) begin
      trunc_cnt++;
      trunc_cyc = cyc;
    end
  end

  initial begin
    int t0;
    int base;
    int tc0;
    hold = '0;
    fifo_wr_full = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_ready", 32'(req_ready), 0);
    check_eq("rst_wr_en", 32'(fifo_wr_en), 0);
    check_eq("rst_trunc", 32'(trunc_err), 0);
    check_eq("rst_owner", 32'(owner), 0);
    check_eq("rst_wr_data", 32'(fifo_wr_data), 0);
    rst_n = 1'b1;
    @(negedge clk); #1;

    // Fairness: all four valid, two 1-beat packets each, from rr_ptr=0.
    wr_cyc.delete();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NR; i++) begin
        push_pkt(i, 8'(16 * i + k), 1'b1);
        exp_q.push_back(word(1'b1, i, 8'(16 * i + k)));
      end
    end
    wait_drain(200);
    check_eq("rr_count", wr_cyc.size(), 8);
    for (int k = 0; k + 1 < wr_cyc.size(); k++) check_eq("rr_gap", wr_cyc[k+1] - wr_cyc[k], 2);

    // Single packet on req 2: bubble then three back-to-back beats.
    wr_cyc.delete();
    t0 = cyc;
    push_pkt(2, 8'hA1, 1'b0);
    push_pkt(2, 8'hA2, 1'b0);
    push_pkt(2, 8'hA3, 1'b1);
    exp_q.push_back(word(1'b0, 2, 8'hA1));
    exp_q.push_back(word(1'b0, 2, 8'hA2));
    exp_q.push_back(word(1'b1, 2, 8'hA3));
    wait_drain(100);
    check_eq("sp_bubble", cyc_at(0) - t0, 2);
    check_eq("sp_gap1", cyc_at(1) - cyc_at(0), 1);
    check_eq("sp_gap2", cyc_at(2) - cyc_at(1), 1);
    check_eq("sp_busy_off", 32'(busy), 0);
    check_eq("sp_owner", 32'(owner), 2);

    // Backpressure: full held 5 cycles after the first beat of a req 1 packet.
    wr_cyc.delete();
    base = wr_total;
    push_pkt(1, 8'hB1, 1'b0);
    push_pkt(1, 8'hB2, 1'b0);
    push_pkt(1, 8'hB3, 1'b1);
    exp_q.push_back(word(1'b0, 1, 8'hB1));
    exp_q.push_back(word(1'b0, 1, 8'hB2));
    exp_q.push_back(word(1'b1, 1, 8'hB3));
    wait_writes(base + 1, 50);
    @(posedge clk); #1;
    fifo_wr_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      check_eq("bp_ready", 32'(req_ready[1]), 0);
      check_eq("bp_wr_en", 32'(fifo_wr_en), 0);
      check_eq("bp_busy", 32'(busy), 1);
      @(posedge clk); #1;
    end
    fifo_wr_full = 1'b0;
    wait_drain(100);
    check_eq("bp_gap", cyc_at(1) - cyc_at(0), 6);
    check_eq("bp_gap2", cyc_at(2) - cyc_at(1), 1);

    // Truncation: req 0 sends 6 beats; cap of 4 splits it, req 1 slips in between.
    wr_cyc.delete();
    base = wr_total;
    tc0 = trunc_cnt;
    for (int k = 1; k <= 6; k++) push_pkt(0, 8'(8'hD0 + k), k == 6);
    for (int k = 1; k <= 4; k++) exp_q.push_back(word(k == 4, 0, 8'(8'hD0 + k)));
    exp_q.push_back(word(1'b1, 1, 8'hC1));
    exp_q.push_back(word(1'b0, 0, 8'hD5));
    exp_q.push_back(word(1'b1, 0, 8'hD6));
    wait_writes(base + 1, 50);
    push_pkt(1, 8'hC1, 1'b1);
    wait_drain(200);
    check_eq("tr_pulses", trunc_cnt - tc0, 1);
    check_eq("tr_when", trunc_cyc - cyc_at(3), 1);

    // Lock hold: req 3 stalls mid-packet while req 0 waits.
    wr_cyc.delete();
    base = wr_total;
    push_pkt(3, 8'hE1, 1'b0);
    push_pkt(3, 8'hE2, 1'b1);
    push_pkt(0, 8'hF1, 1'b1);
    exp_q.push_back(word(1'b0, 3, 8'hE1));
    exp_q.push_back(word(1'b1, 3, 8'hE2));
    exp_q.push_back(word(1'b1, 0, 8'hF1));
    wait_writes(base + 1, 50);
    hold[3] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      check_eq("lh_busy", 32'(busy), 1);
      check_eq("lh_owner", 32'(owner), 3);
      check_eq("lh_ready0", 32'(req_ready[0]), 0);
      check_eq("lh_wr_en", 32'(fifo_wr_en), 0);
    end
    hold[3] = 1'b0;
    wait_drain(100);

    // Reset mid-packet after 2 beats of req 1, then restart from rr_ptr=0.
    base = wr_total;
    push_pkt(1, 8'h61, 1'b0);
    push_pkt(1, 8'h62, 1'b0);
    push_pkt(1, 8'h63, 1'b1);
    exp_q.push_back(word(1'b0, 1, 8'h61));
    exp_q.push_back(word(1'b0, 1, 8'h62));
    wait_writes(base + 2, 50);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_eq("mr_busy", 32'(busy), 0);
    check_eq("mr_ready", 32'(req_ready), 0);
    check_eq("mr_wr_en", 32'(fifo_wr_en), 0);
    check_eq("mr_wr_data", 32'(fifo_wr_data), 0);
    check_eq("mr_owner", 32'(owner), 0);
    check_eq("mr_trunc", 32'(trunc_err), 0);
    prod_q[1].delete();
    @(negedge clk);
    rst_n = 1'b1;
    push_pkt(1, 8'h71, 1'b1);
    push_pkt(2, 8'h72, 1'b1);
    exp_q.push_back(word(1'b1, 1, 8'h71));
    exp_q.push_back(word(1'b1, 2, 8'h72));
    wait_drain(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin, packet-locked arbiter that shares the write port of one sync_fifo between NUM_REQ producers.
Each producer presents a valid/ready beat stream with a last flag.
The arbiter grants one producer per packet and forwards its beats into the FIFO, tagged with source ID and last.
It sits directly in front of sync_fifo and drives its wr_en/wr_data from its wr_full.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_WIDTH, 8, payload bits per beat
MAX_BEATS, 16, packet length cap in beats (>=1)
ID_WIDTH, $clog2(NUM_REQ), source-ID field width (derived, not overridden)

Ports:
clk  input  1  single clock, all logic on rising edge
rstn  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester beat valid
req_data  input  NUM_REQ*DATA_WIDTH  beats; requester i on bits [i*DATA_WIDTH +: DATA_WIDTH]
req_last  input  NUM_REQ  per-requester end-of-packet flag
req_ready  output  NUM_REQ  per-requester beat accepted
fifo_wr_en  output  1  to sync_fifo wr_en
fifo_wr_data  output  DATA_WIDTH+ID_WIDTH+1  {last, src_id, data} to sync_fifo wr_data
fifo_wr_full  input  1  from sync_fifo wr_full
busy  output  1  a packet is locked
owner  output  ID_WIDTH  current or last granted requester
trunc_err  output  1  one-cycle pulse when a packet is cut at MAX_BEATS

Behaviour:
- Reset (async, rstn low):
  - state=IDLE, rr_ptr=0, owner=0, beat_cnt=0.
  - busy=0, trunc_err=0, req_ready=0, fifo_wr_en=0.
- State IDLE:
  - req_ready=0, fifo_wr_en=0.
  - If any req_valid is high, select the first valid index searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Register that index as owner; go to LOCK. beat_cnt=0.
  - The 1-cycle arbitration bubble is mandatory: the first beat is never accepted in the IDLE cycle.
- State LOCK (busy=1):
  - req_ready[owner] = !fifo_wr_full. All other req_ready bits are 0.
  - fifo_wr_en = req_valid[owner] && !fifo_wr_full. This path is combinational, so there is zero latency from the beat to the FIFO write.
  - fifo_wr_data = {eff_last, owner, req_data[owner]}, where eff_last = req_last[owner] || (beat_cnt==MAX_BEATS-1).
  - On an accepted beat (fifo_wr_en=1): beat_cnt increments.
  - If eff_last: go to IDLE, rr_ptr=owner+1 (wraps to 0 after NUM_REQ-1), beat_cnt=0.
  - If the cap forced last (req_last[owner]=0): pulse trunc_err for exactly the cycle after the accept. The remaining producer beats are arbitrated as a new packet.
  - If owner drops valid mid-packet: the lock is held indefinitely, with no timeout and no grant to others.
  - If fifo_wr_full=1: no beat is accepted, and the state, beat_cnt and rr_ptr are all held.
- owner holds its value in IDLE; it updates only on grant.
- Non-owner req_valid may toggle freely and has no effect.
- When owner's req_last and MAX_BEATS coincide on the same beat: treat as a normal last, with no trunc_err.
- Reset asserted mid-packet:
  - The packet is abandoned and no terminating beat is written.
  - After release, arbitration restarts from rr_ptr=0.
- Throughput: 1 beat/cycle inside a packet, plus 1 idle cycle between packets.

Decomposition:
- Shared package fifo_arb_pkg holds:
  - state encoding localparams: ST_IDLE=1'b0, ST_LOCK=1'b1
  - the field offsets of the packed FIFO word (LAST_BIT, ID_LSB)
- One natural sub-module: rr_pick.
  - Combinational round-robin first-one finder.
  - Inputs: NUM_REQ request vector and rr_ptr.
  - Outputs: grant index and any_req.
- The sync_fifo itself is instantiated by the parent, not inside this block.

Test Plan:
- Single packet:
  - Stimulus: NUM_REQ=4; req 2 sends 3 beats 0xA1,0xA2,0xA3 with last on 0xA3; full=0.
  - Response: a 1-cycle bubble, then three consecutive fifo_wr_en.
  - Required words: {0,2,A1},{0,2,A2},{1,2,A3}. busy deasserts the next cycle; owner=2.
- Round-robin fairness:
  - Stimulus: all four requesters continuously valid, 1-beat packets.
  - Response: grant order is 0,1,2,3,0,1, with exactly one idle cycle between grants.
- Backpressure:
  - Stimulus: during a req 1 packet, hold fifo_wr_full=1 for 5 cycles mid-packet.
  - Response: req_ready[1]=0 and fifo_wr_en=0 for those 5 cycles; no beat is lost or duplicated; the word order is preserved.
- Truncation:
  - Stimulus: MAX_BEATS=4; req 0 sends 6 beats with last only on beat 6.
  - Response: beat 4 is written with last=1 and trunc_err pulses once.
  - The remaining 2 beats form a new packet after re-arbitration.
  - If another requester is valid at that point, rr_ptr=1 grants it first.
- Lock hold:
  - Stimulus: req 3 is granted and sends 1 beat, then drops valid for 10 cycles while req 0 stays valid.
  - Response: busy=1 and owner=3 throughout; req_ready[0]=0; req 3 resumes and completes.
- Reset mid-packet:
  - Stimulus: assert rstn=0 asynchronously after 2 beats of a req 1 packet.
  - Response: all outputs are 0 immediately.
  - After release with req 1 and req 2 valid, req 1 is granted first (rr_ptr=0 search).
